fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the write port of the async FIFO write side among NUM_REQ requesters.
- Round-robin arbitration; the winner holds the port for a burst of up to MAX_BURST words.
- Sits in the write_clk domain, directly upstream of write_control_logic.
- Drives that block's write_enable and the FIFO memory write data; consumes its full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, width of one FIFO word.
- MAX_BURST, 4, maximum words per grant (1..15).

Ports:
- write_clk  in  1  write-domain clock.
- write_rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester word-valid.
- req_last  in  NUM_REQ  marks the final word of a requester's burst.
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  word accepted this cycle when valid and ready are both high.
- full  in  1  FIFO full flag from the write control logic.
- write_enable  out  1  write strobe to the write control logic.
- write_data  out  DATA_WIDTH  word to the FIFO memory.
- owner  out  clog2(NUM_REQ)  current grant holder; valid while busy=1.
- busy  out  1  high in BURST.

Behaviour:
- Reset values, applied asynchronously when write_rst=1:
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - req_ready=0, write_enable=0, write_data=0, busy=0.
- State IDLE:
  - req_ready=0, write_enable=0.
  - If any req_valid, select the first valid index at or after rr_ptr (cyclic search).
  - Register the winner in owner, clear beat_cnt, go to BURST.
  - Arbitration costs exactly 1 cycle; no word transfers in IDLE.
- State BURST:
  - req_ready[owner] = !full; all other ready bits are 0.
  - write_enable = req_valid[owner] & req_ready[owner], combinational.
  - write_data = req_data[owner] slice, combinational mux. It is 0 whenever write_enable=0 so bus toggling is minimised.
  - On each transfer, beat_cnt increments.
  - Exit to IDLE on the next edge when any of these holds:
    - a transfer with req_last[owner]=1;
    - a transfer with beat_cnt+1 == MAX_BURST;
    - req_valid[owner]=0 (requester abandoned the grant).
  - On exit, rr_ptr = owner+1, wrapping modulo NUM_REQ.
- full handling:
  - full=1 in BURST stalls the transfer. beat_cnt and state hold and no timeout applies.
  - Exit on abandonment still applies while full.
- Simultaneous cases:
  - req_last and the MAX_BURST limit on the same transfer cause a single exit.
  - full rising in the same cycle as an intended transfer blocks that transfer, because ready depends on full combinationally.
- A requester whose valid drops and later rises again must re-arbitrate.
- Fairness: a continuously requesting requester is granted within NUM_REQ-1 other bursts.
- Reset mid-burst: the in-flight word is not written, and state returns to IDLE immediately.
- Width rules:
  - beat_cnt is clog2(MAX_BURST+1) bits and never wraps.
  - The rr_ptr increment is explicitly modulo NUM_REQ, which matters for non-power-of-2 counts.

Decomposition:
- Shared package fifo_pkg holds:
  - state typedef {IDLE, BURST};
  - REQ_IDX_W = clog2(NUM_REQ);
  - BEAT_W = clog2(MAX_BURST+1).
- One sub-module, rr_priority_picker:
  - combinational;
  - inputs: request vector and rr_ptr;
  - outputs: winner index and any_valid.
  - It is reused later by the read-side scheduler.
- FSM, counters and the data mux stay in fifo_write_arbiter.

Test Plan:
1. Reset, then req_valid=0001 with 3 words, last on word 3. Expect owner=0, busy=1 one cycle after valid, and 3 consecutive write_enable pulses. Then IDLE and rr_ptr=1.
2. All four requesters valid continuously, req_last=0, MAX_BURST=4. Expect grant order 0,1,2,3,0. Each burst is exactly 4 writes, with a 1-cycle IDLE gap between bursts.
3. Owner 2 mid-burst after 2 writes, full=1 for 5 cycles. Expect req_ready=0 and write_enable=0 for those 5 cycles, beat_cnt held at 2. After full drops, exactly 2 more writes occur.
4. Owner 1 drops req_valid after 1 write. Expect exit to IDLE next cycle, rr_ptr=2, and a pending requester 3 granted before requester 1.
5. write_rst pulsed while owner=3 in BURST with write_enable=1. Expect all outputs 0 immediately (asynchronously) and owner=0. The next grant goes to the lowest valid index.
6. req_last and the 4th beat coincide; separately, valid and full rise together. Expect a single exit in the first case. In the second, no write until full=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter and read-side scheduler.
package fifo_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  localparam int unsigned NumReqDefault   = 4;
  localparam int unsigned MaxBurstDefault = 4;

  // Index width; a single requester still needs a 1-bit index.
  function automatic int unsigned req_idx_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned beat_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int unsigned REQ_IDX_W = req_idx_w(NumReqDefault);
  localparam int unsigned BEAT_W    = beat_w(MaxBurstDefault);

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, searching cyclically.
module rr_priority_picker #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   winner_o,
  output logic              any_valid_o
);

  int unsigned     idx;
  logic [IdxW-1:0] idx_v;
  logic            found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    idx_v    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      // Explicit wrap keeps non-power-of-2 request counts in range.
      idx = 32'(ptr_i) + k;
      if (idx >= NumReq) begin
        idx = idx - NumReq;
      end
      idx_v = IdxW'(idx);
      if (!found && req_i[idx_v]) begin
        found    = 1'b1;
        winner_o = idx_v;
      end
    end
    any_valid_o = found;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ requesters.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned IdxW      = req_idx_w(NUM_REQ),
  localparam int unsigned BeatW     = beat_w(MAX_BURST)
) (
  input  logic                          write_clk,
  input  logic                          write_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [IdxW-1:0]               owner,
  output logic                          busy
);

  localparam logic [BeatW-1:0] MaxBeat = BeatW'(MAX_BURST);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [BeatW-1:0]      beat_inc;
  logic [IdxW-1:0]       pick_idx;
  logic                  pick_any;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  xfer;
  logic                  burst_done;

  rr_priority_picker #(
    .NumReq(NUM_REQ),
    .IdxW  (IdxW)
  ) u_picker (
    .req_i      (req_valid),
    .ptr_i      (rr_ptr_q),
    .winner_o   (pick_idx),
    .any_valid_o(pick_any)
  );

  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign own_data  = req_data[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
  assign beat_inc  = beat_cnt_q + BeatW'(1);
  assign owner     = owner_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    write_enable = 1'b0;
    write_data   = '0;
    busy         = 1'b0;
    xfer         = 1'b0;
    burst_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = StBurst;
        end
      end

      StBurst: begin
        busy               = 1'b1;
        // Ready follows full combinationally so a same-cycle full blocks the word.
        req_ready[owner_q] = ~full;
        xfer               = own_valid & ~full;
        write_enable       = xfer;
        if (xfer) begin
          write_data = own_data;
          beat_cnt_d = beat_inc;
        end
        burst_done = ~own_valid | (xfer & (own_last | (beat_inc == MaxBeat)));
        if (burst_done) begin
          state_d  = StIdle;
          rr_ptr_d = (owner_q == LastIdx) ? '0 : owner_q + IdxW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge write_clk or posedge write_rst) begin
    if (write_rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed table-driven bench for fifo_write_arbiter with hand-written reset-in-burst sequence.
module tb_fifo_write_arbiter;

  logic        write_clk;
  logic        write_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        full;
  logic        write_enable;
  logic [7:0]  write_data;
  logic [1:0]  owner;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [3:0] ready;
    logic       we;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  fifo_write_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (4)
  ) dut (
    .write_clk   (write_clk),
    .write_rst   (write_rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .full        (full),
    .write_enable(write_enable),
    .write_data  (write_data),
    .owner       (owner),
    .busy        (busy)
  );

  initial begin
    write_clk = 1'b0;
    forever #5 write_clk = ~write_clk;
  end

  function automatic logic [7:0] data_of(input logic [1:0] i);
    logic [7:0] base;
    base = 8'hA0;
    return base + 8'h11 * {6'd0, i};
  endfunction

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic f,
                     input logic [3:0] r, input logic w, input logic [1:0] o, input logic b);
    vec_t t;
    t.valid = v;
    t.last  = l;
    t.full  = f;
    t.ready = r;
    t.we    = w;
    t.owner = o;
    t.busy  = b;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
    end
  endtask

  task automatic chk_out(input int row, input logic [3:0] r, input logic w,
                         input logic [1:0] o, input logic b);
    logic [7:0] exp_data;
    exp_data = w ? data_of(o) : 8'h00;
    chk("req_ready", row, 32'(req_ready), 32'(r));
    chk("write_enable", row, 32'(write_enable), 32'(w));
    chk("write_data", row, 32'(write_data), 32'(exp_data));
    chk("owner", row, 32'(owner), 32'(o));
    chk("busy", row, 32'(busy), 32'(b));
  endtask

  initial begin
    logic [1:0] prev;

    // Reset, then a 3-word burst from requester 0 ending on req_last.
    add(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
    add(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    // Requester 1 abandons after one word; pending 3 wins before 1 re-arbitrates.
    add(4'b1010, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    add(4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1);
    add(4'b1000, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b1);
    add(4'b1010, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
    add(4'b1010, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
    // All requesters continuous: order 0,1,2,3,0; 4 words each, 1 idle gap.
    prev = 2'd3;
    for (int g = 0; g < 4; g++) begin
      add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, prev, 1'b0);
      for (int w = 0; w < 4; w++) begin
        add(4'b1111, 4'b0000, 1'b0, 4'b0001 << g, 1'b1, 2'(g), 1'b1);
      end
      prev = 2'(g);
    end
    add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
    add(4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    // Owner 2 stalled by full for 5 cycles after 2 words, then exactly 2 more.
    add(4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    for (int w = 0; w < 2; w++) add(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);
    for (int s = 0; s < 5; s++) add(4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1);
    for (int w = 0; w < 2; w++) add(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);
    add(4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
    add(4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
    // req_last on the 4th word: one exit, fresh burst starts with beat count cleared.
    add(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
    for (int w = 0; w < 3; w++) add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
    add(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
    add(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    // valid and full rise together: no write until full drops; abandon while full.
    add(4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    add(4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1);
    add(4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1);
    add(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);

    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req_last  = 4'b0000;
    full      = 1'b0;
    req_valid = 4'b0000;
    write_rst = 1'b1;
    #2;
    req_valid = 4'b1111;
    #1;
    chk_out(-1, 4'b0000, 1'b0, 2'd0, 1'b0);
    #3;
    req_valid = 4'b0000;
    #1;
    write_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge write_clk);
      #1;
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      full      = vecs[i].full;
      #3;
      chk_out(i, vecs[i].ready, vecs[i].we, vecs[i].owner, vecs[i].busy);
    end

    // Reset asserted mid-burst while owner 3 is writing.
    @(posedge write_clk);
    #1;
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    full      = 1'b0;
    #3;
    chk_out(100, 4'b0000, 1'b0, 2'd1, 1'b0);
    @(posedge write_clk);
    #4;
    chk_out(101, 4'b1000, 1'b1, 2'd3, 1'b1);
    #1;
    write_rst = 1'b1;
    #1;
    chk_out(102, 4'b0000, 1'b0, 2'd0, 1'b0);
    #1;
    write_rst = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk_out(103, 4'b0000, 1'b0, 2'd0, 1'b0);
    @(posedge write_clk);
    #4;
    chk_out(104, 4'b0010, 1'b1, 2'd1, 1'b1);
    req_valid = 4'b0000;
    @(posedge write_clk);
    #4;
    chk_out(105, 4'b0000, 1'b0, 2'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
